// File: rtl/clkinv_seq_pkg.sv
// rtl/clkinv_seq_pkg.sv - shared types and elaboration helpers for the clock-inverter polarity sequencer
package clkinv_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RUN,
        ST_HOLD,
        ST_DRAIN,
        ST_SWITCH,
        ST_SETTLE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic int timer_width(input int gate_wait, input int settle_wait, input int idle_timeout);
        return $clog2(max3(gate_wait, settle_wait, idle_timeout) + 1);
    endfunction

    function automatic bit params_ok(input int nreq, input int gate_wait, input int settle_wait,
                                     input int idle_timeout);
        return (nreq >= 1) && (nreq <= 8) && (gate_wait >= 1) && (settle_wait >= 1) && (idle_timeout >= 1);
    endfunction

endpackage

// File: rtl/clkinv_seq_timer.sv
// rtl/clkinv_seq_timer.sv - loadable down-counter with zero flag shared by HOLD, DRAIN and SETTLE
module clkinv_seq_timer
    import clkinv_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    // Never wraps: a decrement request at zero is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/clkinv_polarity_sequencer.sv
// rtl/clkinv_polarity_sequencer.sv - enable and glitch-free polarity sequencing for one gated invertible clock branch
module clkinv_polarity_sequencer
    import clkinv_seq_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int GATE_WAIT    = 4,
    parameter int SETTLE_WAIT  = 4,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    input  logic            pol_req,
    input  logic            pol_valid,
    output logic            pol_ready,
    output logic            clk_en,
    output logic            inv_sel,
    output logic            busy
);

    localparam int TW = timer_width(GATE_WAIT, SETTLE_WAIT, IDLE_TIMEOUT);

    if (!params_ok(NREQ, GATE_WAIT, SETTLE_WAIT, IDLE_TIMEOUT)) begin : g_bad_params
        $error("clkinv_polarity_sequencer: parameter out of range");
    end

    state_t          state, state_d;
    logic            target, target_d;
    logic            inv_sel_d;
    logic            clk_en_d;
    logic            tmr_load, tmr_dec, tmr_zero, tmr_last;
    logic [TW-1:0]   tmr_val, tmr_count;
    logic            any_req, flip;

    clkinv_seq_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    assign any_req  = |req;
    // pol_ready is only ever high in OFF/RUN/HOLD, so it also qualifies the state.
    assign flip     = pol_valid && pol_ready && (pol_req != inv_sel);
    // HOLD leaves one count early so clk_en falls exactly IDLE_TIMEOUT cycles after the last request.
    assign tmr_last = (tmr_count <= TW'(1));

    always_comb begin
        state_d  = state;
        target_d = target;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_OFF, ST_RUN, ST_HOLD: begin
                if (flip) begin
                    state_d  = ST_DRAIN;
                    target_d = pol_req;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GATE_WAIT - 1);
                end else if (state == ST_OFF) begin
                    if (any_req) state_d = ST_RUN;
                end else if (state == ST_RUN) begin
                    if (!any_req) begin
                        if (IDLE_TIMEOUT == 1) begin
                            state_d = ST_OFF;
                        end else begin
                            state_d  = ST_HOLD;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(IDLE_TIMEOUT - 1);
                        end
                    end
                end else if (any_req) begin
                    state_d = ST_RUN;
                end else if (tmr_last) begin
                    state_d = ST_OFF;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tmr_zero) state_d = ST_SWITCH;
                else          tmr_dec = 1'b1;
            end
            ST_SWITCH: begin
                state_d  = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = TW'(SETTLE_WAIT - 1);
            end
            ST_SETTLE: begin
                if (tmr_zero) state_d = any_req ? ST_RUN : ST_OFF;
                else          tmr_dec = 1'b1;
            end
            default: state_d = ST_OFF;
        endcase
        inv_sel_d = (state == ST_SWITCH) ? target : inv_sel;
        clk_en_d  = (state_d == ST_RUN) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_OFF;
            target    <= 1'b0;
            clk_en    <= 1'b0;
            inv_sel   <= 1'b0;
            ack       <= '0;
            pol_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            target    <= target_d;
            clk_en    <= clk_en_d;
            inv_sel   <= inv_sel_d;
            ack       <= (state_d == ST_RUN) ? (req & {NREQ{clk_en}}) : '0;
            pol_ready <= (state_d == ST_OFF) || (state_d == ST_RUN) || (state_d == ST_HOLD);
            busy      <= (state_d == ST_DRAIN) || (state_d == ST_SWITCH) || (state_d == ST_SETTLE);
        end
    end

    // Saturating ages of the gate-off interval and of the current polarity, used by the safety checks.
    logic [TW-1:0] low_cnt, stable_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            low_cnt    <= '1;
            stable_cnt <= '1;
        end else begin
            if (clk_en)                low_cnt <= '0;
            else if (low_cnt != '1)    low_cnt <= low_cnt + 1'b1;
            if (inv_sel_d != inv_sel)  stable_cnt <= '0;
            else if (stable_cnt != '1) stable_cnt <= stable_cnt + 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            a_gate_before_switch: assert ((inv_sel_d == inv_sel) || (!clk_en && (low_cnt >= TW'(GATE_WAIT))));
            a_settle_before_enable: assert (!(clk_en_d && !clk_en) || (stable_cnt >= TW'(SETTLE_WAIT - 1)));
        end
    end

endmodule
